// File: rtl/stream_classifier_head_if.sv
// Bundles the stream_classifier_head handshake buses.
//   in_data/in_valid/in_ready/in_last : per-position score vector stream (CHANNELS lanes)
//   out_scores/out_class/out_len_err/out_frame_cnt/out_valid/out_ready : pooled frame result
// The master modport is the side feeding scores in and taking results out;
// the slave modport is the classifier itself.
interface stream_classifier_head_if #(
  parameter int VALUE_BITS = 18,
  parameter int CHANNELS   = 10,
  parameter int POSITIONS  = 1,
  parameter int ACC_BITS   = VALUE_BITS + $clog2(POSITIONS + 1)
);
  localparam int CLASS_W = $clog2(CHANNELS);

  logic signed [VALUE_BITS-1:0] in_data [CHANNELS];
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_last;
  logic signed [ACC_BITS-1:0]   out_scores [CHANNELS];
  logic [CLASS_W-1:0]           out_class;
  logic                         out_valid;
  logic                         out_ready;
  logic                         out_len_err;
  logic [15:0]                  out_frame_cnt;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_scores, out_class, out_valid, out_len_err, out_frame_cnt
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_scores, out_class, out_valid, out_len_err, out_frame_cnt
  );
endinterface

// File: rtl/stream_classifier_head.sv
// Streaming classifier head: pools a CHANNELS-wide signed score vector over the
// positions of one frame (sum or max), scans the pooled scores for the arg-max
// class and presents the result on a valid/ready output.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset, aborts any frame in progress
//   bus   : slave side of stream_classifier_head_if (input stream + result)
// Frame flow: CLEAR (1 cycle) -> ACCUM (in_ready=1) -> ARGMAX (CHANNELS cycles)
// -> OUTPUT (held until out_ready). Final beat accepted at edge T gives
// out_valid at T+CHANNELS.
module stream_classifier_head #(
  parameter int VALUE_BITS = 18,
  parameter int CHANNELS   = 10,
  parameter int POSITIONS  = 1,
  parameter int POOL_MODE  = 0,
  parameter int ACC_BITS   = VALUE_BITS + $clog2(POSITIONS + 1)
) (
  input logic                     clk,
  input logic                     reset,
  stream_classifier_head_if.slave bus
);

  localparam int CLASS_W      = $clog2(CHANNELS);
  localparam int CNT_W        = $clog2(POSITIONS + 1);
  localparam int SCAN_W       = $clog2(CHANNELS + 1);
  localparam int MIN_ACC_BITS = VALUE_BITS + $clog2(POSITIONS + 1);

  // Max pooling starts from the most negative representable value so the first
  // beat always wins; sum pooling starts from zero.
  localparam logic signed [ACC_BITS-1:0] ACC_INIT =
    (POOL_MODE == 1) ? {1'b1, {(ACC_BITS-1){1'b0}}} : '0;

  if (ACC_BITS < MIN_ACC_BITS) begin : g_acc_bits_check
    $error("stream_classifier_head: ACC_BITS too small for VALUE_BITS/POSITIONS");
  end
  if (CHANNELS < 2) begin : g_channels_check
    $error("stream_classifier_head: CHANNELS must be >= 2");
  end

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_ACCUM  = 2'd1,
    S_ARGMAX = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  function automatic logic signed [ACC_BITS-1:0] sext(
    input logic signed [VALUE_BITS-1:0] v
  );
    return {{(ACC_BITS-VALUE_BITS){v[VALUE_BITS-1]}}, v};
  endfunction

  // One pooling step; the accumulator is wide enough that sums never wrap.
  function automatic logic signed [ACC_BITS-1:0] pool_step(
    input logic signed [ACC_BITS-1:0]   acc_v,
    input logic signed [VALUE_BITS-1:0] x
  );
    logic signed [ACC_BITS-1:0] xe;
    xe = sext(x);
    if (POOL_MODE == 1) return (xe > acc_v) ? xe : acc_v;
    return acc_v + xe;
  endfunction

  state_t                     state;
  state_t                     state_nxt;
  logic signed [ACC_BITS-1:0] acc [CHANNELS];
  logic signed [ACC_BITS-1:0] best_val;
  logic [CLASS_W-1:0]         best_idx;
  logic [CNT_W-1:0]           beat_cnt;
  logic [CNT_W-1:0]           cnt_nxt;
  logic [SCAN_W-1:0]          scan_idx;
  logic                       in_ready_c;
  logic                       out_valid_c;
  logic                       accept;
  logic                       frame_end;
  logic                       len_err_nxt;
  logic                       scan_done;
  logic                       take_new;
  logic [CLASS_W-1:0]         ch_sel;
  logic [CLASS_W-1:0]         cand_idx;
  logic signed [ACC_BITS-1:0] cand_val;
  logic signed [ACC_BITS-1:0] scores_q [CHANNELS];
  logic [CLASS_W-1:0]         class_q;
  logic                       len_err_q;
  logic [15:0]                frame_cnt_q;

  // ---- FSM state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_nxt;
  end

  // ---- FSM next state ----
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_CLEAR:  state_nxt = S_ACCUM;
      S_ACCUM:  if (frame_end)     state_nxt = S_ARGMAX;
      S_ARGMAX: if (scan_done)     state_nxt = S_OUTPUT;
      S_OUTPUT: if (bus.out_ready) state_nxt = S_CLEAR;
      default:  state_nxt = S_CLEAR;
    endcase
  end

  // ---- FSM outputs ----
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    unique case (state)
      S_ACCUM:  in_ready_c  = 1'b1;
      S_OUTPUT: out_valid_c = 1'b1;
      default: begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
      end
    endcase
  end

  // Frame termination and arg-max candidate selection.
  always_comb begin
    accept      = bus.in_valid && in_ready_c;
    cnt_nxt     = beat_cnt + CNT_W'(1);
    frame_end   = accept && (bus.in_last || (cnt_nxt == CNT_W'(POSITIONS)));
    // Clean only when in_last lands exactly on the POSITIONS-th beat.
    len_err_nxt = !(bus.in_last && (cnt_nxt == CNT_W'(POSITIONS)));
    scan_done   = (scan_idx == SCAN_W'(CHANNELS));
    ch_sel      = scan_done ? '0 : CLASS_W'(scan_idx);
    // The first scan step compares channel 1 against channel 0 directly, so the
    // seed never has to be captured while the accumulators are still updating.
    cand_val    = (scan_idx == SCAN_W'(1)) ? acc[0] : best_val;
    cand_idx    = (scan_idx == SCAN_W'(1)) ? '0     : best_idx;
    // Strictly greater: ties keep the lower channel index.
    take_new    = acc[ch_sel] > cand_val;
  end

  // ---- pooling accumulators and arg-max scan (no reset: CLEAR initialises) ----
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      for (int c = 0; c < CHANNELS; c++) acc[c] <= ACC_INIT;
    end else if (accept) begin
      for (int c = 0; c < CHANNELS; c++) acc[c] <= pool_step(acc[c], bus.in_data[c]);
    end

    if (state == S_ARGMAX && !scan_done) begin
      best_val <= take_new ? acc[ch_sel] : cand_val;
      best_idx <= take_new ? ch_sel      : cand_idx;
    end
  end

  // ---- control counters and registered result ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt    <= '0;
      scan_idx    <= SCAN_W'(1);
      class_q     <= '0;
      len_err_q   <= 1'b0;
      frame_cnt_q <= '0;
      for (int c = 0; c < CHANNELS; c++) scores_q[c] <= '0;
    end else begin
      unique case (state)
        S_CLEAR: begin
          beat_cnt <= '0;
          scan_idx <= SCAN_W'(1);
        end
        S_ACCUM: begin
          if (accept) beat_cnt <= cnt_nxt;
          if (frame_end) len_err_q <= len_err_nxt;
        end
        S_ARGMAX: begin
          if (scan_done) begin
            class_q <= best_idx;
            for (int c = 0; c < CHANNELS; c++) scores_q[c] <= acc[c];
          end else begin
            scan_idx <= scan_idx + SCAN_W'(1);
          end
        end
        S_OUTPUT: begin
          if (bus.out_ready) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
        default: beat_cnt <= '0;
      endcase
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.out_valid     = out_valid_c;
  assign bus.out_scores    = scores_q;
  assign bus.out_class     = class_q;
  assign bus.out_len_err   = len_err_q;
  assign bus.out_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_stream_classifier_head.sv
// Bench for stream_classifier_head: three instances (10ch/1pos sum,
// 4ch/4pos sum, 4ch/4pos max). The two 4-channel instances share one stimulus
// stream; results are compared against a frame-level reference model.
module tb_stream_classifier_head;
  localparam int VB      = 18;
  localparam int CA      = 10;
  localparam int C       = 4;
  localparam int P       = 4;
  localparam int TIMEOUT = 200;

  typedef int vec_t [C];

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   exp_frames = 0;
  int   exp_frames_a = 0;
  int   t_last = 0;
  vec_t stim [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_classifier_head_if #(.VALUE_BITS(VB), .CHANNELS(CA), .POSITIONS(1)) if_a ();
  stream_classifier_head_if #(.VALUE_BITS(VB), .CHANNELS(C),  .POSITIONS(P)) if_b ();
  stream_classifier_head_if #(.VALUE_BITS(VB), .CHANNELS(C),  .POSITIONS(P)) if_m ();

  stream_classifier_head #(.VALUE_BITS(VB), .CHANNELS(CA), .POSITIONS(1), .POOL_MODE(0))
    dut_a (.clk(clk), .reset(reset), .bus(if_a));
  stream_classifier_head #(.VALUE_BITS(VB), .CHANNELS(C), .POSITIONS(P), .POOL_MODE(0))
    dut_b (.clk(clk), .reset(reset), .bus(if_b));
  stream_classifier_head #(.VALUE_BITS(VB), .CHANNELS(C), .POSITIONS(P), .POOL_MODE(1))
    dut_m (.clk(clk), .reset(reset), .bus(if_m));

  assign if_m.in_valid  = if_b.in_valid;
  assign if_m.in_last   = if_b.in_last;
  assign if_m.in_data   = if_b.in_data;
  assign if_m.out_ready = if_b.out_ready;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd_val();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  task automatic push_vec(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    stim.push_back(v);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) push_vec(rnd_val(), rnd_val(), rnd_val(), rnd_val());
  endtask

  // Presents one beat on the shared 4-channel stream and waits for acceptance.
  task automatic send_beat(input vec_t v, input bit last);
    int n;
    n = 0;
    for (int c = 0; c < C; c++) if_b.in_data[c] = VB'(v[c]);
    if_b.in_last  = last;
    if_b.in_valid = 1'b1;
    while (!if_b.in_ready && n < TIMEOUT) begin
      tick();
      n++;
    end
    chk("beat_accept_in_time", longint'(n < TIMEOUT), 1);
    tick();
    t_last = cyc;
    if_b.in_valid = 1'b0;
    if_b.in_last  = 1'b0;
  endtask

  // Sends the queued beats as one frame, checks both 4-channel results against
  // the model, optionally stalls the output, then completes the handshake.
  task automatic run_frame(input bit last_on_final, input int stall, input string tag);
    int es [C];
    int em [C];
    int cs, cm, nb, n;
    bit ee;
    nb = stim.size();
    for (int c = 0; c < C; c++) begin
      es[c] = 0;
      em[c] = stim[0][c];
    end
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < C; c++) begin
        es[c] += stim[b][c];
        if (stim[b][c] > em[c]) em[c] = stim[b][c];
      end
    end
    cs = 0;
    cm = 0;
    for (int c = 1; c < C; c++) begin
      if (es[c] > es[cs]) cs = c;
      if (em[c] > em[cm]) cm = c;
    end
    ee = (nb != P) || !last_on_final;

    for (int b = 0; b < nb; b++) send_beat(stim[b], last_on_final && (b == nb - 1));
    n = 0;
    while (!if_b.out_valid && n < TIMEOUT) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, cyc - t_last, C);
    chk({tag, "_m_valid"}, if_m.out_valid, 1);
    for (int c = 0; c < C; c++) begin
      chk($sformatf("%s_sum_s%0d", tag, c), if_b.out_scores[c], es[c]);
      chk($sformatf("%s_max_s%0d", tag, c), if_m.out_scores[c], em[c]);
    end
    chk({tag, "_sum_class"}, if_b.out_class, cs);
    chk({tag, "_max_class"}, if_m.out_class, cm);
    chk({tag, "_sum_len_err"}, if_b.out_len_err, ee);
    chk({tag, "_max_len_err"}, if_m.out_len_err, ee);
    chk({tag, "_frame_cnt"}, if_b.out_frame_cnt, exp_frames & 16'hFFFF);

    if (stall > 0) begin
      if_b.in_valid = 1'b1;
      for (int c = 0; c < C; c++) if_b.in_data[c] = VB'(rnd_val());
      for (int i = 0; i < stall; i++) begin
        tick();
        chk("stall_in_ready", if_b.in_ready, 0);
        chk("stall_out_valid", if_b.out_valid, 1);
        chk("stall_class", if_b.out_class, cs);
        chk("stall_score0", if_b.out_scores[0], es[0]);
        chk("stall_max3", if_m.out_scores[3], em[3]);
        chk("stall_frame_cnt", if_b.out_frame_cnt, exp_frames & 16'hFFFF);
      end
      if_b.in_valid = 1'b0;
    end

    if_b.out_ready = 1'b1;
    tick();
    if_b.out_ready = 1'b0;
    exp_frames++;
    chk({tag, "_valid_drop"}, if_b.out_valid, 0);
    chk({tag, "_frame_cnt_inc"}, if_b.out_frame_cnt, exp_frames & 16'hFFFF);
    stim.delete();
  endtask

  // Single-position frames on the 10-channel instance; dom7 plants a clear
  // winner on channel 7.
  task automatic run_a(input bit dom7, input bit last, input string tag);
    int v [CA];
    int ec, n, t_acc;
    for (int c = 0; c < CA; c++)
      v[c] = dom7 ? int'($urandom_range(0, 197371)) - 131072 : rnd_val();
    if (dom7) v[7] = 111662;
    ec = 0;
    for (int c = 1; c < CA; c++) if (v[c] > v[ec]) ec = c;
    for (int c = 0; c < CA; c++) if_a.in_data[c] = VB'(v[c]);
    if_a.in_last  = last;
    if_a.in_valid = 1'b1;
    n = 0;
    while (!if_a.in_ready && n < TIMEOUT) begin
      tick();
      n++;
    end
    tick();
    t_acc = cyc;
    if_a.in_valid = 1'b0;
    if_a.in_last  = 1'b0;
    n = 0;
    while (!if_a.out_valid && n < TIMEOUT) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, cyc - t_acc, CA);
    for (int c = 0; c < CA; c++) chk($sformatf("%s_s%0d", tag, c), if_a.out_scores[c], v[c]);
    chk({tag, "_class"}, if_a.out_class, ec);
    chk({tag, "_len_err"}, if_a.out_len_err, !last);
    chk({tag, "_frame_cnt"}, if_a.out_frame_cnt, exp_frames_a);
    if_a.out_ready = 1'b1;
    tick();
    if_a.out_ready = 1'b0;
    exp_frames_a++;
    chk({tag, "_frame_cnt_inc"}, if_a.out_frame_cnt, exp_frames_a);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_b_in_ready"}, if_b.in_ready, 0);
    chk({tag, "_b_out_valid"}, if_b.out_valid, 0);
    chk({tag, "_b_class"}, if_b.out_class, 0);
    chk({tag, "_b_len_err"}, if_b.out_len_err, 0);
    chk({tag, "_b_frame_cnt"}, if_b.out_frame_cnt, 0);
    chk({tag, "_m_out_valid"}, if_m.out_valid, 0);
    chk({tag, "_a_in_ready"}, if_a.in_ready, 0);
    chk({tag, "_a_frame_cnt"}, if_a.out_frame_cnt, 0);
    for (int c = 0; c < C; c++) begin
      chk($sformatf("%s_b_s%0d", tag, c), if_b.out_scores[c], 0);
      chk($sformatf("%s_m_s%0d", tag, c), if_m.out_scores[c], 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    if_a.in_valid = 1'b0;
    if_a.in_last = 1'b0;
    if_a.out_ready = 1'b0;
    for (int c = 0; c < CA; c++) if_a.in_data[c] = '0;
    if_b.in_valid = 1'b0;
    if_b.in_last = 1'b0;
    if_b.out_ready = 1'b0;
    for (int c = 0; c < C; c++) if_b.in_data[c] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("por");
    reset = 1'b0;

    // 10 channels, single position
    run_a(1'b1, 1'b1, "a_dom7");
    run_a(1'b0, 1'b1, "a_rand");
    run_a(1'b0, 1'b0, "a_nolast");
    run_a(1'b1, 1'b1, "a_dom7b");

    // fixed sum frame
    for (int i = 0; i < P; i++) push_vec(100, -50, 7, -3);
    run_frame(1'b1, 0, "sum_fix");
    chk("sum_fix_s0", if_b.out_scores[0], 400);
    chk("sum_fix_s1", if_b.out_scores[1], -200);
    chk("sum_fix_s2", if_b.out_scores[2], 28);
    chk("sum_fix_s3", if_b.out_scores[3], -12);

    // fixed max frame with a tie between channels 2 and 3
    push_vec(-5, -9, -1, -7);
    push_vec(-8, -2, -4, -6);
    push_vec(-3, -10, -2, -9);
    push_vec(-6, -4, -8, -1);
    run_frame(1'b1, 0, "max_fix");
    chk("max_fix_s0", if_m.out_scores[0], -3);
    chk("max_fix_s1", if_m.out_scores[1], -2);
    chk("max_fix_s2", if_m.out_scores[2], -1);
    chk("max_fix_s3", if_m.out_scores[3], -1);
    chk("max_fix_tie_class", if_m.out_class, 2);

    // length errors: early in_last, missing in_last, then a clean frame
    push_rand(2);
    run_frame(1'b1, 0, "short");
    push_rand(P);
    run_frame(1'b0, 0, "nolast");
    push_rand(P);
    run_frame(1'b1, 0, "clean");

    // output back-pressure with upstream still offering beats
    push_rand(P);
    run_frame(1'b1, 20, "stall");
    push_rand(P);
    run_frame(1'b1, 0, "post_stall");

    // random frames of random length
    for (int k = 0; k < 8; k++) begin
      int nb;
      bit lst;
      nb  = int'($urandom_range(1, P));
      lst = (nb < P) ? 1'b1 : 1'($urandom_range(0, 1));
      push_rand(nb);
      run_frame(lst, 0, $sformatf("rnd%0d", k));
    end

    // reset mid-frame
    push_rand(P);
    send_beat(stim[0], 1'b0);
    send_beat(stim[1], 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("midreset");
    tick();
    reset = 1'b0;
    exp_frames = 0;
    exp_frames_a = 0;
    stim.delete();
    push_rand(P);
    run_frame(1'b1, 0, "after_reset");
    chk("after_reset_frame_cnt", if_b.out_frame_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
